// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and default framing.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 16;
    localparam int unsigned UART_DATA_BITS    = 8;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = uart_pkg::UART_DATA_BITS
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
    modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, reset to a chosen level.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of a synchronized serial line, framing check,
// and single-entry holding register presented on a valid/ready handshake.
module uart_rx import uart_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_rx_bit,
    uart_rx_if.master bus
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS) + 1;

    uart_state_e          r_state;
    uart_state_e          w_state_nxt;
    logic [CNT_W-1:0]     r_clk_cnt,  w_clk_cnt_nxt;
    logic [IDX_W-1:0]     r_bit_idx,  w_bit_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic [DATA_BITS-1:0] r_rx_data,  w_data_nxt;
    logic                 r_rx_valid, w_valid_nxt;
    logic                 r_frame_err, w_ferr_nxt;
    logic                 r_overrun,  w_ovr_nxt;
    logic                 w_rx_s;
    logic                 w_half_tick;
    logic                 w_bit_tick;
    logic                 w_last_bit;

    uart_sync2 #(.RST_VAL(UART_IDLE_LVL)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_rx_bit),
        .o_q (w_rx_s)
    );

    assign w_half_tick = (r_clk_cnt == CNT_W'(CLKS_PER_BIT/2 - 1));
    assign w_bit_tick  = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_last_bit  = (r_bit_idx == IDX_W'(DATA_BITS - 1));

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clk_cnt   <= w_clk_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_rx_data   <= w_data_nxt;
            r_rx_valid  <= w_valid_nxt;
            r_frame_err <= w_ferr_nxt;
            r_overrun   <= w_ovr_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_rx_s == UART_START_LVL) w_state_nxt = START;
            START:     if (w_half_tick) w_state_nxt = (w_rx_s == UART_START_LVL) ? DATA : IDLE;
            DATA:      if (w_bit_tick && w_last_bit) w_state_nxt = STOP;
            STOP:      if (w_bit_tick) w_state_nxt = (w_rx_s == UART_IDLE_LVL) ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (w_rx_s == UART_IDLE_LVL) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // Counters, shifter and holding-register updates; delivery decided at the stop sample
    always_comb begin
        w_clk_cnt_nxt = '0;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_rx_data;
        w_valid_nxt   = r_rx_valid & ~bus.rx_ready;
        w_ferr_nxt    = 1'b0;
        w_ovr_nxt     = 1'b0;
        case (r_state)
            START: begin
                if (w_half_tick) w_bit_idx_nxt = '0;
                else             w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
            end
            DATA: begin
                if (w_bit_tick) begin
                    w_shift_nxt   = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (!w_bit_tick) begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end else if (w_rx_s != UART_IDLE_LVL) begin
                    w_ferr_nxt = 1'b1;
                end else if (!r_rx_valid || bus.rx_ready) begin
                    w_data_nxt  = r_shift;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_ovr_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the stage directly downstream of the UART transmitter. Consumes its serial line and recovers parallel bytes.
- Samples an asynchronous serial input using a per-bit clock-count timebase.
- Checks start and stop framing.
- Presents each received byte on a valid/ready interface to the consuming logic (FIFO or register file).

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4.
- DATA_BITS, 8, data bits per frame; 5..8.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rx_bit  input  1  serial line, asynchronous to clk; idle high.
- rx_ready  input  1  consumer accepts rx_data this cycle when rx_valid=1.
- rx_data  output  DATA_BITS  received byte, LSB = first data bit on the line.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a byte was dropped because the holding register was full.

Behaviour:
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1). No parity.
- Input path:
  - rx_bit passes through a 2-flop synchronizer; both flops reset to 1.
  - All decisions use the synchronized value rx_s, so there are 2 cycles of latency.
- Reset (rst=0, async): state=IDLE, counters=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, shift register=0.
- Reset mid-frame aborts the frame with no output.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rx_s=0 → START, clk_cnt=0.
- START:
  - At clk_cnt = CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - rx_s=0 → DATA, clk_cnt=0, bit_idx=0.
  - rx_s=1 → false start; return to IDLE with no output.
- DATA:
  - At clk_cnt = CLKS_PER_BIT-1 (mid data bit), shift rx_s into the MSB of a right-shift register and reset clk_cnt.
  - After bit_idx = DATA_BITS-1 → STOP; otherwise increment bit_idx.
- STOP:
  - At clk_cnt = CLKS_PER_BIT-1 (mid stop bit), sample rx_s.
  - rx_s=1: frame good; deliver the byte the next cycle; → IDLE.
  - rx_s=0: frame_err pulses 1 cycle; byte discarded; → WAIT_IDLE.
- WAIT_IDLE:
  - Stays until rx_s=1 (break or line-low condition), then → IDLE.
  - No start detection while in this state.
- Delivery, on the cycle after a good stop sample:
  - rx_valid=0: load rx_data, set rx_valid=1.
  - rx_valid=1 and rx_ready=1 in the same cycle: load the new byte; rx_valid stays 1; no overrun.
  - rx_valid=1 and rx_ready=0: keep the old rx_data; drop the new byte; overrun pulses 1 cycle.
- Handshake:
  - rx_valid clears the cycle after rx_valid & rx_ready, unless a new byte loads in that same cycle.
  - rx_data is stable while rx_valid=1 and not accepted.
- Back-to-back frames: the next start bit may follow the stop bit immediately. Returning to IDLE at mid stop bit guarantees the next falling edge is detected.
- Bit timing uses mid-bit sampling, with up to 1 clk of detection jitter. Tolerated baud mismatch is about ±4% at CLKS_PER_BIT=16.
- Width rules:
  - clk_cnt width = $clog2(CLKS_PER_BIT).
  - bit_idx width = $clog2(DATA_BITS)+1.
  - No counter wraps within a bit period.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding enum (IDLE, START, DATA, STOP, WAIT_IDLE).
  - Line-level constants: UART_IDLE_LVL=1, UART_START_LVL=0.
  - Default CLKS_PER_BIT and DATA_BITS, shared with the transmitter.
- One sub-module, uart_sync2:
  - Parameterizable 2-flop synchronizer with a reset value parameter.
  - Reusable for other asynchronous inputs.

Test Plan (all at CLKS_PER_BIT=16, DATA_BITS=8):
- Good frame: drive 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) at 16 clk/bit, rx_ready=1 → rx_valid pulses 1 cycle with rx_data=0xA5; frame_err=0, overrun=0.
- False start: 5-cycle low glitch on an idle line → no rx_valid and no frame_err; the following frame 0x3C is received correctly.
- Framing error: frame 0x81 with stop bit held low, then the line held low for 40 cycles before returning high → frame_err pulses once, rx_valid stays 0; a subsequent frame 0x55 is received correctly.
- Overrun: rx_ready=0, send 0x11 then 0x22 back-to-back → rx_data=0x11 with rx_valid=1; overrun pulses once after the second stop bit. Then assert rx_ready → rx_valid drops and rx_data remains 0x11.
- Simultaneous accept: rx_valid=1 holding 0x11, and rx_ready=1 in the exact cycle 0x22 completes → rx_data=0x22, rx_valid=1, overrun=0.
- Reset mid-frame: assert rst during data bit 4 of 0xF0 → all outputs 0 immediately. Release rst and send 0x0F → rx_data=0x0F with no spurious valid before it.
